uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle ready/frame-error strobes.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the o_parity_err output.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_ready,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;

    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
            $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_rx: DATA_BITS must be in 5..9");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
            $error("uart_rx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;
    logic                 w_half_done;
    logic                 w_bit_done;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 w_par_bit_nxt;
    logic                 r_parity_err;
    logic                 w_parity_err_nxt;
    logic                 w_par_exp;
`endif

    // Line is idle-high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s      = r_sync2;
    assign w_half_done = (r_cnt == CNT_W'(HALF - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
`ifdef UART_RX_PARITY_EN
    assign w_par_exp   = (^r_shift) ^ (PARITY_ODD != 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_data       <= w_data_nxt;
            r_ready      <= w_ready_nxt;
            r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_data_nxt       = r_data;
        w_ready_nxt      = 1'b0;
        w_frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_half_done) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_cnt_nxt     = '0;
                    w_par_bit_nxt = w_rx_s;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_ready_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        w_parity_err_nxt = (r_par_bit != w_par_exp);
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not read as frames.
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_data       = r_data;
    assign o_ready      = r_ready;
    assign o_frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal, back-to-back, glitch, break, mid-frame reset (and parity when enabled).
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif
    // Drive just after edge T0; rx_s low after T0+2; FSM sees it at E0=T0+3;
    // stop sampled at E0+HALF+(FRAME_BITS-1)*CPB; seen at the following negedge.
    localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DB-1:0] o_data;
    logic          o_ready;
    logic          o_frame_err;
    logic          o_busy;
`ifdef UART_RX_PARITY_EN
    logic          o_parity_err;
`endif

    int total = 0;
    int bad   = 0;

    int            cyc = 0;
    int            n_ready = 0;
    int            n_ferr = 0;
    int            n_both = 0;
    int            n_rdy_perr = 0;
    int            n_perr = 0;
    int            rdy_cyc = 0;
    logic [DB-1:0] last_data = '0;
    logic          busy_seen = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_uart_rx    (rx),
        .o_data       (o_data),
        .o_ready      (o_ready),
        .o_frame_err  (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (o_parity_err),
`endif
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_ready) begin
            n_ready   = n_ready + 1;
            rdy_cyc   = cyc;
            last_data = o_data;
        end
        if (o_frame_err) n_ferr = n_ferr + 1;
        if (o_ready && o_frame_err) n_both = n_both + 1;
        if (o_busy) busy_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) n_perr = n_perr + 1;
        if (o_ready && o_parity_err) n_rdy_perr = n_rdy_perr + 1;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(CPB);
    endtask

    task automatic send_frame_p(input logic [DB-1:0] d, input logic stop_v, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_v);
`else
        if (par_v !== 1'bx) begin end
`endif
        send_bit(stop_v);
    endtask

    // Frame with correct even parity (parity only transmitted when enabled).
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v);
        send_frame_p(d, stop_v, ^d);
    endtask

    initial begin
        int c0;
        int r0;
        int f0;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(3);
        check("reset_data",  32'(o_data), 32'h0);
        check("reset_ready", 32'(o_ready), 32'h0);
        check("reset_ferr",  32'(o_frame_err), 32'h0);
        check("reset_busy",  32'(o_busy), 32'h0);
        rst = 1'b0;
        wait_clk(4);

        // Nominal 0x55
        c0 = cyc;
        r0 = n_ready;
        send_frame(8'h55, 1'b1);
        wait_clk(2);
        check("nom_ready_cnt", 32'(n_ready - r0), 32'd1);
        check("nom_latency",   32'(rdy_cyc - c0), 32'(LAT));
        check("nom_data",      32'(o_data), 32'h55);
        check("nom_busy_after", 32'(o_busy), 32'h0);
        check("nom_no_ferr",   32'(n_ferr), 32'd0);

        // Back-to-back 0xAA, 0x0F with no idle gap
        r0 = n_ready;
        send_frame(8'hAA, 1'b1);
        check("b2b_first_data", 32'(last_data), 32'hAA);
        send_frame(8'h0F, 1'b1);
        wait_clk(2);
        check("b2b_ready_cnt", 32'(n_ready - r0), 32'd2);
        check("b2b_data",      32'(o_data), 32'h0F);
        check("b2b_no_ferr",   32'(n_ferr), 32'd0);

        // Start glitch: two clocks low
        busy_seen = 1'b0;
        r0 = n_ready;
        rx = 1'b0;
        wait_clk(2);
        rx = 1'b1;
        wait_clk(20);
        check("glitch_busy_pulse", 32'(busy_seen), 32'h1);
        check("glitch_no_ready",   32'(n_ready - r0), 32'd0);
        check("glitch_no_ferr",    32'(n_ferr), 32'd0);
        check("glitch_data",       32'(o_data), 32'h0F);
        check("glitch_idle",       32'(o_busy), 32'h0);

        // Bad stop bit followed by a held-low line
        r0 = n_ready;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        wait_clk(40);
        check("brk_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check("brk_no_ready", 32'(n_ready - r0), 32'd0);
        check("brk_data_kept", 32'(o_data), 32'h0F);
        check("brk_busy_wait", 32'(o_busy), 32'h1);
        rx = 1'b1;
        wait_clk(16);
        check("brk_idle_after_high", 32'(o_busy), 32'h0);
        send_frame(8'h81, 1'b1);
        wait_clk(2);
        check("brk_next_ready", 32'(n_ready - r0), 32'd1);
        check("brk_next_data",  32'(o_data), 32'h81);
        check("brk_ferr_total", 32'(n_ferr - f0), 32'd1);

        // Asynchronous reset during data bit 3 of 0xFF
        r0 = n_ready;
        f0 = n_ferr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clk(CPB / 2);
        rst = 1'b1;
        #1;
        check("mrst_data",  32'(o_data), 32'h0);
        check("mrst_ready", 32'(o_ready), 32'h0);
        check("mrst_ferr",  32'(o_frame_err), 32'h0);
        check("mrst_busy",  32'(o_busy), 32'h0);
        wait_clk(2);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clk(3 * CPB);
        check("mrst_no_strobe", 32'(n_ready - r0), 32'd0);
        send_frame(8'h12, 1'b1);
        wait_clk(2);
        check("mrst_next_ready", 32'(n_ready - r0), 32'd1);
        check("mrst_next_data",  32'(o_data), 32'h12);
        check("mrst_no_ferr",    32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        r0 = n_ready;
        f0 = n_perr;
        send_frame_p(8'h07, 1'b1, 1'b1);
        wait_clk(2);
        check("par_ok_ready", 32'(n_ready - r0), 32'd1);
        check("par_ok_perr",  32'(n_perr - f0), 32'd0);
        c0 = n_rdy_perr;
        send_frame_p(8'h07, 1'b1, 1'b0);
        wait_clk(2);
        check("par_bad_ready",    32'(n_ready - r0), 32'd2);
        check("par_bad_together", 32'(n_rdy_perr - c0), 32'd1);
        check("par_bad_perr",     32'(n_perr - f0), 32'd1);
        check("par_bad_data",     32'(o_data), 32'h07);
`endif

        check("never_ready_and_ferr", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
